// File: rtl/video_mode_pkg.sv
// Shared definitions for the video mode decode/commit path: mode-vector layout,
// reset (ZX) vector, commit FSM states and Z80-side mode codes.
package video_mode_pkg;

    localparam int unsigned ModeW = 11;

    localparam int unsigned IdxAtmNPent = 0;
    localparam int unsigned IdxZx       = 1;
    localparam int unsigned IdxP16c     = 2;
    localparam int unsigned IdxPHmclr   = 3;
    localparam int unsigned IdxAHmclr   = 4;
    localparam int unsigned IdxA16c     = 5;
    localparam int unsigned IdxAText    = 6;
    localparam int unsigned IdxATxt1p   = 7;
    localparam int unsigned IdxPixf14   = 8;
    localparam int unsigned IdxBwLo     = 9;
    localparam int unsigned IdxBwHi     = 10;

    // ZX decode: only the zx flag set, bandwidth 1/8
    localparam logic [ModeW-1:0] ModeReset = 11'h002;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StArmed,
        StBlank
    } state_e;

    localparam logic [2:0] AtmPent   = 3'b011;
    localparam logic [2:0] AtmHmclr  = 3'b010;
    localparam logic [2:0] Atm16c    = 3'b000;
    localparam logic [2:0] AtmText   = 3'b110;
    localparam logic [2:0] AtmText1p = 3'b111;

    localparam logic [1:0] PentZx    = 2'b00;
    localparam logic [1:0] PentHmclr = 2'b01;
    localparam logic [1:0] Pent16c   = 2'b10;
    localparam logic [1:0] PentZxAlt = 2'b11;

endpackage

// File: rtl/video_mode_lut.sv
// Combinational decode of pent_vmode/atm_vmode into the packed mode vector.
module video_mode_lut
    import video_mode_pkg::*;
(
    input  logic [1:0]       pent_vmode,
    input  logic [2:0]       atm_vmode,
    output logic [ModeW-1:0] mode
);

    logic atm_mode;
    logic pent_mode;

    always_comb begin
        atm_mode  = (atm_vmode == AtmHmclr) || (atm_vmode == Atm16c) ||
                    (atm_vmode == AtmText)  || (atm_vmode == AtmText1p);
        // undefined atm codes fall back to pent modes
        pent_mode = !atm_mode;

        mode                   = '0;
        mode[IdxAtmNPent]      = atm_mode;
        mode[IdxZx]            = pent_mode &&
                                 ((pent_vmode == PentZx) || (pent_vmode == PentZxAlt));
        mode[IdxP16c]          = pent_mode && (pent_vmode == Pent16c);
        mode[IdxPHmclr]        = pent_mode && (pent_vmode == PentHmclr);
        mode[IdxAHmclr]        = (atm_vmode == AtmHmclr);
        mode[IdxA16c]          = (atm_vmode == Atm16c);
        mode[IdxAText]         = (atm_vmode == AtmText) || (atm_vmode == AtmText1p);
        mode[IdxATxt1p]        = (atm_vmode == AtmText1p);
        mode[IdxPixf14]        = (atm_vmode == AtmHmclr) || (atm_vmode == AtmText) ||
                                 (atm_vmode == AtmText1p);
        mode[IdxBwHi:IdxBwLo]  = (pent_mode && (pent_vmode != Pent16c)) ? 2'b00 : 2'b01;
    end

endmodule

// File: rtl/video_modesync.sv
// Debounces the decoded video mode and commits it only at a frame boundary,
// optionally forcing a few blank frames after each switch.
module video_modesync
    import video_mode_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned BLANK_FRAMES  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pent_vmode,
    input  logic [2:0] atm_vmode,
    input  logic       frame_start,
    output logic       mode_atm_n_pent,
    output logic       mode_zx,
    output logic       mode_p_16c,
    output logic       mode_p_hmclr,
    output logic       mode_a_hmclr,
    output logic       mode_a_16c,
    output logic       mode_a_text,
    output logic       mode_a_txt_1page,
    output logic       mode_pixf_14,
    output logic [1:0] mode_bw,
    output logic       mode_blank,
    output logic       mode_changed,
    output logic       mode_pending
);

    localparam logic [7:0] ScntLast = 8'(STABLE_CYCLES - 1);
    localparam logic [3:0] FcntInit = (BLANK_FRAMES == 0) ? 4'd0 : 4'(BLANK_FRAMES - 1);

    logic [ModeW-1:0] lut_mode;
    logic [ModeW-1:0] req_q, req_prev_q;
    logic [ModeW-1:0] active_q, active_d;
    logic [ModeW-1:0] pend_q, pend_d;
    logic [7:0]       scnt_q, scnt_d;
    logic [3:0]       fcnt_q, fcnt_d;
    logic             changed_q, commit;
    state_e           state_q, state_d;

    video_mode_lut u_lut (
        .pent_vmode (pent_vmode),
        .atm_vmode  (atm_vmode),
        .mode       (lut_mode)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= ModeReset;
            req_prev_q <= ModeReset;
            active_q   <= ModeReset;
            pend_q     <= ModeReset;
            scnt_q     <= '0;
            fcnt_q     <= '0;
            changed_q  <= 1'b0;
            state_q    <= StIdle;
        end else begin
            req_q      <= lut_mode;
            req_prev_q <= req_q;
            active_q   <= active_d;
            pend_q     <= pend_d;
            scnt_q     <= scnt_d;
            fcnt_q     <= fcnt_d;
            changed_q  <= commit;
            state_q    <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        scnt_d   = scnt_q;
        fcnt_d   = fcnt_q;
        active_d = active_q;
        pend_d   = pend_q;
        commit   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_q != active_q) begin
                    state_d = StSettle;
                    scnt_d  = '0;
                end
            end
            StSettle: begin
                if (req_q == active_q) begin
                    state_d = StIdle;
                end else if (req_q != req_prev_q) begin
                    scnt_d = '0;
                end else if (scnt_q == ScntLast) begin
                    state_d = StArmed;
                    pend_d  = req_q;
                end else begin
                    scnt_d = scnt_q + 8'd1;
                end
            end
            StArmed: begin
                // a changed request beats a coincident frame_start
                if (req_q == active_q) begin
                    state_d = StIdle;
                end else if (req_q != pend_q) begin
                    state_d = StSettle;
                    scnt_d  = '0;
                end else if (frame_start) begin
                    active_d = pend_q;
                    commit   = 1'b1;
                    if (BLANK_FRAMES > 0) begin
                        state_d = StBlank;
                        fcnt_d  = FcntInit;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StBlank: begin
                if (frame_start) begin
                    if (fcnt_q == 4'd0) state_d = StIdle;
                    else                fcnt_d  = fcnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign mode_atm_n_pent  = active_q[IdxAtmNPent];
    assign mode_zx          = active_q[IdxZx];
    assign mode_p_16c       = active_q[IdxP16c];
    assign mode_p_hmclr     = active_q[IdxPHmclr];
    assign mode_a_hmclr     = active_q[IdxAHmclr];
    assign mode_a_16c       = active_q[IdxA16c];
    assign mode_a_text      = active_q[IdxAText];
    assign mode_a_txt_1page = active_q[IdxATxt1p];
    assign mode_pixf_14     = active_q[IdxPixf14];
    assign mode_bw          = active_q[IdxBwHi:IdxBwLo];
    assign mode_blank       = (state_q == StBlank);
    assign mode_changed     = changed_q;
    assign mode_pending     = (state_q == StSettle) || (state_q == StArmed);

endmodule
